jtbubl_main_comm: RTL

JTBUBL_MAIN_COMM -- requirements
Module: jtbubl_main_comm

---
 rtl/jtbubl_main_comm_pkg.sv | 37 +++
 rtl/jtbubl_main_comm_fifo.sv | 63 ++++++
 rtl/jtbubl_main_comm.sv | 103 ++++++++++
 3 files changed

// File: rtl/jtbubl_main_comm_pkg.sv
// Shared register map, status/control bit positions and FIFO defaults for the
// main/sound communication window; also consumed by the sound-side block.
package jtbubl_main_comm_pkg;

  localparam int COMM_FIFO_AW = 2;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  localparam int CTRL_INT_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam int STAT_OVF    = 7;
  localparam int STAT_PEND   = 6;
  localparam int STAT_FULL   = 5;
  localparam int STAT_INT_EN = 4;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_kind_e;

  function automatic logic [7:0] pack_status(input logic ovf, input logic pend,
                                             input logic full, input logic int_en,
                                             input logic [2:0] cnt);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_OVF]    = ovf;
    s[STAT_PEND]   = pend;
    s[STAT_FULL]   = full;
    s[STAT_INT_EN] = int_en;
    s[2:0]         = cnt;
    return s;
  endfunction

endpackage

// File: rtl/jtbubl_main_comm_fifo.sv
// Small reply FIFO (sound CPU -> main CPU) with flush; a push that coincides
// with a flush becomes the sole entry.
module jtbubl_comm_fifo
  import jtbubl_main_comm_pkg::*;
#(
  parameter int AW = COMM_FIFO_AW,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          snd_rstn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push, w_do_pop;
  logic [AW-1:0] w_waddr;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when a slot frees up in the same cycle.
  assign w_do_push = i_push && (!o_full || i_pop || i_flush);
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_waddr   = i_flush ? '0 : r_wr_ptr;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_waddr] <= i_din;
  end

  always_ff @(posedge clk or negedge snd_rstn) begin
    if (!snd_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= AW'(w_do_push);
      r_count  <= (AW+1)'(w_do_push);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jtbubl_main_comm.sv
// Main-CPU side of the sound communication window: command latch, control and
// status registers, and decoding of CPU accesses into single-shot actions.
module jtbubl_main_comm
  import jtbubl_main_comm_pkg::*;
#(
  parameter int FIFO_AW = COMM_FIFO_AW
) (
  input  logic       clk,
  input  logic       snd_rstn,
  input  logic       main_cs,
  input  logic       main_addr,
  input  logic       main_rd_n,
  input  logic       main_wr_n,
  input  logic [7:0] main_dout,
  output logic [7:0] comm_dout,
  output logic [7:0] snd_latch,
  output logic       snd_stb,
  input  logic       snd_flag,
  input  logic [7:0] main_latch,
  input  logic       main_stb,
  output logic       main_flag,
  output logic       main_int_n
);

  logic            r_active_prev, r_armed, r_stb_prev;
  logic            r_snd_stb, r_int_en, r_ovf;
  logic [7:0]      r_snd_latch, r_comm_dout;
  logic            w_active, w_start, w_stb_rise;
  acc_kind_e       w_kind;
  logic            w_wr_data, w_wr_ctrl, w_rd_data, w_rd_ctrl;
  logic            w_pop, w_flush, w_set_ovf;
  logic [7:0]      w_head;
  logic [FIFO_AW:0] w_count;
  logic [2:0]      w_cnt3;
  logic            w_full, w_empty;

  // r_armed stays low until the bus is seen idle, so an access still held
  // across reset release is never taken as a new one.
  assign w_active   = main_cs && (!main_rd_n || !main_wr_n);
  assign w_start    = w_active && !r_active_prev && r_armed;
  assign w_kind     = !w_start ? ACC_NONE : (!main_wr_n ? ACC_WRITE : ACC_READ);
  assign w_wr_data  = (w_kind == ACC_WRITE) && (main_addr == REG_DATA);
  assign w_wr_ctrl  = (w_kind == ACC_WRITE) && (main_addr == REG_CTRL);
  assign w_rd_data  = (w_kind == ACC_READ)  && (main_addr == REG_DATA);
  assign w_rd_ctrl  = (w_kind == ACC_READ)  && (main_addr == REG_CTRL);

  assign w_stb_rise = main_stb && !r_stb_prev;
  assign w_pop      = w_rd_data && !w_empty;
  assign w_flush    = w_wr_ctrl && main_dout[CTRL_FLUSH];
  assign w_set_ovf  = w_stb_rise && w_full && !w_pop && !w_flush;
  assign w_cnt3     = 3'(w_count);

  jtbubl_comm_fifo #(
    .AW (FIFO_AW),
    .DW (8)
  ) u_fifo (
    .clk      (clk),
    .snd_rstn (snd_rstn),
    .i_push   (w_stb_rise),
    .i_pop    (w_pop),
    .i_flush  (w_flush),
    .i_din    (main_latch),
    .o_dout   (w_head),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk or negedge snd_rstn) begin
    if (!snd_rstn) begin
      r_active_prev <= 1'b0;
      r_armed       <= 1'b0;
      r_stb_prev    <= 1'b0;
      r_snd_stb     <= 1'b0;
      r_snd_latch   <= 8'h00;
      r_int_en      <= 1'b0;
      r_ovf         <= 1'b0;
      r_comm_dout   <= 8'hFF;
    end else begin
      r_active_prev <= w_active;
      if (!w_active) r_armed <= 1'b1;
      r_stb_prev    <= main_stb;
      r_snd_stb     <= w_wr_data;
      if (w_wr_data) r_snd_latch <= main_dout;
      if (w_wr_ctrl) r_int_en <= main_dout[CTRL_INT_EN];
      if (w_rd_data) begin
        r_comm_dout <= w_empty ? 8'hFF : w_head;
      end else if (w_rd_ctrl) begin
        r_comm_dout <= pack_status(r_ovf, ~snd_flag, w_full, r_int_en, w_cnt3);
      end
      // A status read returns the old flag; a coincident overflow wins.
      if (w_set_ovf)      r_ovf <= 1'b1;
      else if (w_rd_ctrl) r_ovf <= 1'b0;
    end
  end

  assign comm_dout  = r_comm_dout;
  assign snd_latch  = r_snd_latch;
  assign snd_stb    = r_snd_stb;
  assign main_flag  = !w_empty;
  assign main_int_n = ~(r_int_en && !w_empty);

endmodule
